// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter; define PS2_TX_RESEND_EN for up to 2 automatic retries
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int IW = $clog2(INHIBIT_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int FW = $clog2(FILTER_LEN);

    typedef enum logic [3:0] {IDLE, INHIBIT, RELEASE, SEND, STOP, ACK, WAITIDLE, OK, FAIL} state_t;

    state_t        state, state_n;
    logic [1:0]    clk_s, data_s;
    logic [FW-1:0] fcnt;
    logic          clk_f, clk_f_d, fall;
    logic [IW-1:0] icnt, icnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [3:0]    bitcnt, bitcnt_n;
    logic [8:0]    shreg, shreg_n, frame;
    logic          data_oe_n, accept, timeout, retry;

    assign tx_ready   = state == IDLE;
    assign busy       = !tx_ready;
    assign accept     = tx_valid && tx_ready;
    assign timeout    = tcnt == TW'(TIMEOUT_CYCLES - 1);
    assign ps2_clk_oe = state == INHIBIT || state == RELEASE;
    assign done       = state == OK;
    assign error      = state == FAIL && !retry;
    assign fall       = clk_f_d && !clk_f;

`ifdef PS2_TX_RESEND_EN
    logic [1:0] rcnt;
    logic [7:0] byte_q;

    assign retry = rcnt != 2'd2;
    assign frame = {~^byte_q, byte_q};

    // keep the accepted byte for retransmission and count consecutive failed attempts
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rcnt   <= '0;
            byte_q <= '0;
        end else if (accept) begin
            rcnt   <= '0;
            byte_q <= tx_data;
        end else if (state == FAIL && retry) begin
            rcnt <= rcnt + 1'b1;
        end
    end
`else
    assign retry = 1'b0;
    assign frame = '0;
`endif

    // synchronise both pins and accept a new ps2_clk level only after FILTER_LEN equal samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_s   <= 2'b11;
            data_s  <= 2'b11;
            fcnt    <= '0;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
        end else begin
            clk_s   <= {clk_s[0], ps2_clk_in};
            data_s  <= {data_s[0], ps2_data_in};
            clk_f_d <= clk_f;
            if (clk_s[1] == clk_f) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                clk_f <= clk_s[1];
                fcnt  <= '0;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

    // state and datapath registers; reset releases both lines on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            icnt        <= '0;
            tcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            ps2_data_oe <= 1'b0;
        end else begin
            state       <= state_n;
            icnt        <= icnt_n;
            tcnt        <= tcnt_n;
            bitcnt      <= bitcnt_n;
            shreg       <= shreg_n;
            ps2_data_oe <= data_oe_n;
        end
    end

    // next-state logic: inhibit, request, then shift one bit per device falling edge
    always_comb begin
        state_n   = state;
        icnt_n    = icnt;
        tcnt_n    = tcnt;
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        data_oe_n = ps2_data_oe;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = INHIBIT;
                    icnt_n  = '0;
                    shreg_n = {~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                icnt_n = icnt + 1'b1;
                if (icnt == IW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;
                    state_n   = RELEASE;
                end
            end
            RELEASE: begin
                tcnt_n   = '0;
                bitcnt_n = '0;
                state_n  = SEND;
            end
            SEND, STOP, ACK, WAITIDLE: begin
                tcnt_n = tcnt + 1'b1;
                if (timeout) begin
                    data_oe_n = 1'b0;
                    state_n   = FAIL;
                end else if (state == WAITIDLE) begin
                    state_n = (clk_f && data_s[1]) ? OK : WAITIDLE;
                end else if (fall) begin
                    if (state == SEND) begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = shreg >> 1;
                        bitcnt_n  = bitcnt + 1'b1;
                        state_n   = (bitcnt == 4'd8) ? STOP : SEND;
                    end else if (state == STOP) begin
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        state_n = data_s[1] ? FAIL : WAITIDLE;
                    end
                end
            end
            OK: state_n = IDLE;
            FAIL: begin
                data_oe_n = 1'b0;
                state_n   = retry ? INHIBIT : IDLE;
                icnt_n    = '0;
                shreg_n   = retry ? frame : shreg;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench for ps2_host_tx with an open-drain keyboard model and a frame scoreboard
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH = 2500;
    localparam int TMO = 4000;
    localparam int H   = 20;
`ifdef PS2_TX_RESEND_EN
    localparam int NATT = 3;
`else
    localparam int NATT = 1;
`endif

    typedef struct {
        logic [7:0] d;
        bit         nack;
        bit         hold;
        bit         glitch;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, error;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       clk_oe_d = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         n_done = 0;
    int         n_err = 0;
    int         n_inh = 0;
    logic [10:0] exp_q[$];
    vec_t       vecs[5];

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(8)) dut (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in), .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done), .error(error)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2) == 0;
        return {1'b1, p, d, 1'b0};
    endfunction

    // pulse counters and line-release check on every done/error
    initial forever begin
        @(negedge clk);
        if (ps2_clk_oe && !clk_oe_d) n_inh++;
        clk_oe_d = ps2_clk_oe;
        if (done) n_done++;
        if (error) begin
            n_err++;
            check("error_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic device(input bit nack, input bit glitch);
        logic [10:0] got;
        int g;
        g = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_in === 1'b0) && g < 4 * INH) begin
            @(negedge clk);
            g++;
        end
        check("device_sees_request", g < 4 * INH, 1);
        repeat (H) @(negedge clk);
        got[0] = ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            got[i] = ps2_data_in;
            if (glitch && i <= 9) begin
                repeat (5) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (H - 8) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        dev_data_low = !nack;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge clk);
        dev_data_low = 1'b0;
        if (exp_q.size() == 0) check("scoreboard_nonempty", 0, 1);
        else check("frame", 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic wait_ready(input string name);
        int g;
        g = 0;
        while (!tx_ready && g < 20 * H) begin
            @(negedge clk);
            g++;
        end
        check(name, tx_ready, 1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0, e0, i0, n, att;
        att = v.nack ? NATT : 1;
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        wait_ready("ready_before_tx");
        tx_data = v.d;
        tx_valid = 1'b1;
        for (int k = 0; k < att; k++) exp_q.push_back(frame(v.d));
        @(negedge clk);
        check("busy_after_accept", busy, 1);
        tx_valid = v.hold;
        tx_data = ~v.d;
        for (int a = 0; a < att; a++) begin
            n = 0;
            while (!ps2_clk_oe && n < 8 * H) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (ps2_clk_oe && !ps2_data_oe && n < 2 * INH) begin
                @(negedge clk);
                n++;
            end
            if (a == 0) check("inhibit_cycles", n, INH);
            n = 0;
            while (ps2_clk_oe && ps2_data_oe && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("release_cycles", n, 1);
            device(v.nack, v.glitch);
        end
        tx_valid = 1'b0;
        wait_ready("ready_after_tx");
        @(negedge clk);
        check("busy_after_tx", busy, 0);
        check("done_count", n_done - d0, !v.nack);
        check("error_count", n_err - e0, v.nack);
        check("inhibit_phases", n_inh - i0, att);
    endtask

    initial begin
        int n, d0, e0, i0;
        vecs[0] = '{d: 8'hED, nack: 1'b0, hold: 1'b0, glitch: 1'b0};
        vecs[1] = '{d: 8'hF4, nack: 1'b0, hold: 1'b1, glitch: 1'b0};
        vecs[2] = '{d: 8'hA5, nack: 1'b1, hold: 1'b0, glitch: 1'b0};
        vecs[3] = '{d: 8'h3C, nack: 1'b0, hold: 1'b0, glitch: 1'b1};
        vecs[4] = '{d: 8'h00, nack: 1'b0, hold: 1'b0, glitch: 1'b0};
        repeat (3) @(negedge clk);
        check("reset_tx_ready", tx_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done_error", {done, error}, 0);
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);
        check("frame_0xED_literal", 32'(frame(8'hED)), 32'(11'b1_1_11101101_0));

        // device never clocks: every attempt ends in a timeout
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        tx_data = 8'h12;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int a = 0; a < NATT; a++) begin
            n = 0;
            while (!ps2_clk_oe && n < 8 * H) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (ps2_clk_oe && n < 2 * INH) begin
                @(negedge clk);
                n++;
            end
            n = 0;
            while (!error && !ps2_clk_oe && n < TMO + 10) begin
                @(negedge clk);
                n++;
            end
            check("timeout_cycles", n, (a == NATT - 1) ? TMO : TMO + 1);
        end
        check("timeout_released", {ps2_clk_oe, ps2_data_oe}, 0);
        wait_ready("ready_after_timeout");
        @(negedge clk);
        check("timeout_error_count", n_err - e0, 1);
        check("timeout_done_count", n_done - d0, 0);
        check("timeout_inhibit_phases", n_inh - i0, NATT);

        // reset while the 4th data bit is on the line
        tx_data = 8'h50;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        n = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_in === 1'b0) && n < 4 * INH) begin
            @(negedge clk);
            n++;
        end
        repeat (H) @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            dev_clk_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        check("pre_reset_data_oe", ps2_data_oe, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("midreset_ready", tx_ready, 1);
        check("midreset_busy", busy, 0);
        reset_n = 1'b1;
        repeat (2 * H) @(negedge clk);
        run_vec('{d: 8'hFF, nack: 1'b0, hold: 1'b0, glitch: 1'b0});
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
